ssp_rx_ctrl: RTL and testbench

Receive-side controller for the SSP receive path. Samples the serial inputs (SSPCLKIN, SSPFSSIN, SSPRXD) in the PCLK domain and detects TI-style frame syncs. Deserialises 8-bit frames MSB-first and sequences writes into the 4-entry receive FIFO through RxData and the FIFO's write strobe. Owns overrun detection (FIFO full at delivery) and frame-error detection (sync mid-frame). Sits between the SSP pins and the receive FIFO, entirely on PCLK.

---
 rtl/ssp_rx_ctrl_if.sv | 17 +
 rtl/ssp_rx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ssp_rx_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ssp_rx_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ssp_rx_ctrl_if
// Brief    : Receive-FIFO write port between the SSP receive controller and
//            the 4-entry receive FIFO.
// Revision : 1.0  initial release
// ============================================================================
interface ssp_rx_ctrl_if;
  logic [7:0] RxData;    // assembled byte, held until the next write
  logic       rx_write;  // one-PCLK write strobe
  logic       rx_full;   // FIFO full indication

  modport master (output RxData, output rx_write, input  rx_full);
  modport slave  (input  RxData, input  rx_write, output rx_full);
endinterface
`default_nettype wire

// File: rtl/ssp_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ssp_rx_ctrl
// Brief    : SSP receive controller. Synchronises the serial pins into PCLK,
//            detects TI-style frame syncs, deserialises 8-bit MSB-first
//            frames and writes them to the receive FIFO. Flags overrun and
//            frame errors as sticky bits.
// Revision : 1.0  initial release
// ============================================================================
module ssp_rx_ctrl (
  input  logic           PCLK,
  input  logic           CLEAR_B,
  input  logic           rx_enable,
  input  logic           SSPCLKIN,
  input  logic           SSPFSSIN,
  input  logic           SSPRXD,
  input  logic           err_clr,
  ssp_rx_ctrl_if.master  fifo,
  output logic           rx_busy,
  output logic           rx_overrun,
  output logic           rx_frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

  localparam logic [2:0] C_BIT_MSB = 3'd7;

  // Synchroniser flops; the serial clock gets a third stage for edge detect
  logic       r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic       r_fss_s1,  r_fss_s2;
  logic       r_rxd_s1,  r_rxd_s2;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_pend, w_pend_nxt;
  logic [7:0] r_rx_data;
  logic       r_rx_write;
  logic       r_overrun;
  logic       r_frame_err;

  logic       w_fall_det;
  logic       w_load;
  logic       w_ovr_set;
  logic       w_ferr_set;

  // Bring the asynchronous serial pins into the PCLK domain
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_s3 <= 1'b1;
      r_fss_s1  <= 1'b0;
      r_fss_s2  <= 1'b0;
      r_rxd_s1  <= 1'b0;
      r_rxd_s2  <= 1'b0;
    end else begin
      r_sclk_s1 <= SSPCLKIN;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_fss_s1  <= SSPFSSIN;
      r_fss_s2  <= r_fss_s1;
      r_rxd_s1  <= SSPRXD;
      r_rxd_s2  <= r_rxd_s1;
    end
  end

  // Falling edge of the synchronised serial clock is the sampling instant
  assign w_fall_det = ~r_sclk_s2 & r_sclk_s3;

  // Frame FSM: next state, datapath next values and delivery decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_pend_nxt    = r_pend;
    w_load        = 1'b0;
    w_ovr_set     = 1'b0;
    w_ferr_set    = 1'b0;

    if (!rx_enable) begin
      // Disabling abandons any frame in flight without touching the flags
      w_state_nxt = ST_IDLE;
      w_pend_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The data bit of the sync period carries nothing and is skipped
          if (w_fall_det && r_fss_s2) begin
            w_state_nxt   = ST_SHIFT;
            w_bit_cnt_nxt = C_BIT_MSB;
          end
        end

        ST_SHIFT: begin
          if (w_fall_det) begin
            if (r_fss_s2 && (r_bit_cnt != 3'd0)) begin
              // Sync arrived mid-frame: drop the partial byte, restart
              w_ferr_set    = 1'b1;
              w_bit_cnt_nxt = C_BIT_MSB;
            end else begin
              w_shift_nxt = {r_shift[6:0], r_rxd_s2};
              if (r_bit_cnt == 3'd0) begin
                // Sync on the LSB announces a back-to-back frame
                w_state_nxt = ST_DELIVER;
                w_pend_nxt  = r_fss_s2;
              end else begin
                w_bit_cnt_nxt = r_bit_cnt - 3'd1;
              end
            end
          end
        end

        ST_DELIVER: begin
          if (fifo.rx_full) begin
            w_ovr_set = 1'b1;
          end else begin
            w_load = 1'b1;
          end
          if (r_pend) begin
            w_state_nxt   = ST_SHIFT;
            w_bit_cnt_nxt = C_BIT_MSB;
            w_pend_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and frame datapath registers
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_pend    <= w_pend_nxt;
    end
  end

  // FIFO write port: registered strobe with data held between writes
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_rx_data  <= 8'h00;
      r_rx_write <= 1'b0;
    end else begin
      r_rx_write <= w_load;
      if (w_load) begin
        r_rx_data <= r_shift;
      end
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= w_ovr_set  | (r_overrun   & ~err_clr);
      r_frame_err <= w_ferr_set | (r_frame_err & ~err_clr);
    end
  end

  assign fifo.RxData   = r_rx_data;
  assign fifo.rx_write = r_rx_write;
  assign rx_busy       = (r_state != ST_IDLE);
  assign rx_overrun    = r_overrun;
  assign rx_frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ssp_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ssp_rx_ctrl
// Brief    : Directed self-checking bench for ssp_rx_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_ssp_rx_ctrl;

  logic PCLK      = 1'b0;
  logic CLEAR_B   = 1'b0;
  logic rx_enable = 1'b0;
  logic SSPCLKIN  = 1'b1;
  logic SSPFSSIN  = 1'b0;
  logic SSPRXD    = 1'b0;
  logic err_clr   = 1'b0;
  logic rx_busy;
  logic rx_overrun;
  logic rx_frame_err;

  ssp_rx_ctrl_if fifo ();

  ssp_rx_ctrl dut (
    .PCLK         (PCLK),
    .CLEAR_B      (CLEAR_B),
    .rx_enable    (rx_enable),
    .SSPCLKIN     (SSPCLKIN),
    .SSPFSSIN     (SSPFSSIN),
    .SSPRXD       (SSPRXD),
    .err_clr      (err_clr),
    .fifo         (fifo),
    .rx_busy      (rx_busy),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         fall_cyc = 0;
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];
  bit         gap_q[$];
  bit         idle_since_wr = 1'b0;

  // 100 MHz PCLK
  always #5 PCLK = ~PCLK;

  // PCLK edge counter
  always @(posedge PCLK) cyc <= cyc + 1;

  // Record every FIFO write and whether rx_busy dropped since the previous one
  always @(negedge PCLK) begin
    if (fifo.rx_write === 1'b1) begin
      wr_data_q.push_back(fifo.RxData);
      wr_cyc_q.push_back(cyc);
      gap_q.push_back(idle_since_wr);
      idle_since_wr = 1'b0;
    end
    if (rx_busy !== 1'b1) idle_since_wr = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One serial bit: 6 PCLK high, falling edge, 6 PCLK low; optional err_clr
  // pulse aligned with the DELIVER cycle that follows this fall
  task automatic ssp_bit(input logic fss, input logic d, input bit clr_pulse);
    @(negedge PCLK);
    SSPFSSIN = fss;
    SSPRXD   = d;
    SSPCLKIN = 1'b1;
    repeat (6) @(negedge PCLK);
    SSPCLKIN = 1'b0;
    fall_cyc = cyc;
    if (clr_pulse) begin
      repeat (3) @(negedge PCLK);
      err_clr = 1'b1;
      @(negedge PCLK);
      err_clr = 1'b0;
      repeat (2) @(negedge PCLK);
    end else begin
      repeat (6) @(negedge PCLK);
    end
  endtask

  // Top n bits of b, MSB first; fss_last/clr_last apply to the final bit
  task automatic send_bits(input logic [7:0] b, input int n, input logic fss_last, input bit clr_last);
    for (int i = 7; i >= 8 - n; i--) begin
      ssp_bit((i == 8 - n) ? fss_last : 1'b0, b[i], (i == 8 - n) ? clr_last : 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic fss_last, input bit clr_last);
    ssp_bit(1'b1, 1'b0, 1'b0);
    send_bits(b, 8, fss_last, clr_last);
  endtask

  initial begin
    fifo.rx_full = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_rxdata",  {24'd0, fifo.RxData}, 32'h00);
    chk("rst_write",   {31'd0, fifo.rx_write}, 32'd0);
    chk("rst_busy",    {31'd0, rx_busy}, 32'd0);
    chk("rst_ovr",     {31'd0, rx_overrun}, 32'd0);
    chk("rst_ferr",    {31'd0, rx_frame_err}, 32'd0);
    CLEAR_B   = 1'b1;
    rx_enable = 1'b1;
    repeat (3) @(negedge PCLK);

    // Single frame
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (8) @(negedge PCLK);
    chk("t1_count",   wr_data_q.size(), 32'd1);
    chk("t1_data",    {24'd0, wr_data_q[0]}, 32'hA5);
    chk("t1_latency", wr_cyc_q[0] - fall_cyc, 32'd4);
    chk("t1_busy",    {31'd0, rx_busy}, 32'd0);
    chk("t1_ovr",     {31'd0, rx_overrun}, 32'd0);
    chk("t1_ferr",    {31'd0, rx_frame_err}, 32'd0);

    // Back-to-back frames, sync during the LSB of the first
    send_frame(8'h3C, 1'b1, 1'b0);
    send_bits(8'hC3, 8, 1'b0, 1'b0);
    repeat (8) @(negedge PCLK);
    chk("t2_count",  wr_data_q.size(), 32'd3);
    chk("t2_data0",  {24'd0, wr_data_q[1]}, 32'h3C);
    chk("t2_data1",  {24'd0, wr_data_q[2]}, 32'hC3);
    chk("t2_no_gap", {31'd0, gap_q[2]}, 32'd0);

    // Sync after 4 bits, then a full frame
    ssp_bit(1'b1, 1'b0, 1'b0);
    send_bits(8'hF0, 4, 1'b0, 1'b0);
    ssp_bit(1'b1, 1'b1, 1'b0);
    send_bits(8'h81, 8, 1'b0, 1'b0);
    repeat (8) @(negedge PCLK);
    chk("t3_ferr",  {31'd0, rx_frame_err}, 32'd1);
    chk("t3_count", wr_data_q.size(), 32'd4);
    chk("t3_data",  {24'd0, wr_data_q[3]}, 32'h81);
    chk("t3_ovr",   {31'd0, rx_overrun}, 32'd0);

    // Receiver disabled after 5 bits, re-enabled before the next frame
    ssp_bit(1'b1, 1'b0, 1'b0);
    send_bits(8'hFF, 5, 1'b0, 1'b0);
    chk("t4_busy_pre", {31'd0, rx_busy}, 32'd1);
    rx_enable = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("t4_busy_off", {31'd0, rx_busy}, 32'd0);
    rx_enable = 1'b1;
    send_frame(8'h7E, 1'b0, 1'b0);
    repeat (8) @(negedge PCLK);
    chk("t4_count", wr_data_q.size(), 32'd5);
    chk("t4_data",  {24'd0, wr_data_q[4]}, 32'h7E);
    chk("t4_ferr",  {31'd0, rx_frame_err}, 32'd1);

    // FIFO full at delivery
    fifo.rx_full = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (8) @(negedge PCLK);
    fifo.rx_full = 1'b0;
    chk("t5_count",  wr_data_q.size(), 32'd5);
    chk("t5_rxdata", {24'd0, fifo.RxData}, 32'h7E);
    chk("t5_ovr",    {31'd0, rx_overrun}, 32'd1);
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    #1;
    chk("t5_ovr_clr",  {31'd0, rx_overrun}, 32'd0);
    chk("t5_ferr_clr", {31'd0, rx_frame_err}, 32'd0);
    fifo.rx_full = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (8) @(negedge PCLK);
    fifo.rx_full = 1'b0;
    chk("t5_set_wins", {31'd0, rx_overrun}, 32'd1);
    chk("t5_count2",   wr_data_q.size(), 32'd5);

    // Asynchronous reset after 3 bits of a frame
    ssp_bit(1'b1, 1'b0, 1'b0);
    send_bits(8'hAA, 3, 1'b0, 1'b0);
    chk("t6_busy_pre", {31'd0, rx_busy}, 32'd1);
    #2 CLEAR_B = 1'b0;
    #1;
    chk("t6_rxdata", {24'd0, fifo.RxData}, 32'h00);
    chk("t6_write",  {31'd0, fifo.rx_write}, 32'd0);
    chk("t6_busy",   {31'd0, rx_busy}, 32'd0);
    chk("t6_ovr",    {31'd0, rx_overrun}, 32'd0);
    chk("t6_ferr",   {31'd0, rx_frame_err}, 32'd0);
    repeat (3) @(negedge PCLK);
    CLEAR_B = 1'b1;
    repeat (3) @(negedge PCLK);
    send_frame(8'h0F, 1'b0, 1'b0);
    repeat (8) @(negedge PCLK);
    chk("t6_count", wr_data_q.size(), 32'd6);
    chk("t6_data",  {24'd0, wr_data_q[5]}, 32'h0F);
    chk("t6_ferr2", {31'd0, rx_frame_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
